// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-pass sequencer that runs W-bit XOR/AND/ADD/SUB
// operations through an external 4-bit ALU, one nibble per cycle, LSB first.
// The carry is chained between passes in a register. Requests arrive and
// results leave over valid/ready handshakes.
module alu_seq_ctrl #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic                   req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_carry,
    output logic                   rsp_ovf,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cin,
    output logic [1:0]             alu_sel,
    input  logic [3:0]             alu_result,
    input  logic                   alu_cout
);

    localparam int W = 4 * NIBBLES;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t         state;
    logic [1:0]     cnt;
    logic [1:0]     op_q;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic           a_msb;
    logic           b_msb;
    logic           carry_q;
    logic [1:0]     sel_q;
    logic [W-1:0]   res_q;

    logic [W-1:0]   res_next;
    logic           last_pass;
    logic           arith;
    logic           ovf_next;

    // The ALU drive comes straight from registers; the operand shift
    // registers present the current nibble in their low four bits, and
    // the carry register doubles as the ALU carry-in.
    assign alu_a      = a_sh[3:0];
    assign alu_b      = b_sh[3:0];
    assign alu_cin    = carry_q;
    assign alu_sel    = sel_q;
    assign rsp_result = res_q;

    // Merge the current ALU nibble into the partial result and derive the
    // overflow flag from the operand sign bits and the final result sign.
    always_comb begin
        res_next = res_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == 2'(i)) begin
                res_next[4*i +: 4] = alu_result;
            end
        end
        last_pass = (cnt == 2'(NIBBLES - 1));
        arith     = op_q[1];
        ovf_next  = arith
                    & (op_q[0] ? (a_msb != b_msb) : (a_msb == b_msb))
                    & (res_next[W-1] != a_msb);
    end

    // Sequencer FSM: accept a request, run one ALU pass per cycle, then hold
    // the registered response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_XOR;
            a_sh      <= '0;
            b_sh      <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            carry_q   <= 1'b0;
            sel_q     <= 2'b00;
            res_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        a_sh      <= req_a;
                        b_sh      <= (req_op == OP_SUB) ? ~req_b : req_b;
                        a_msb     <= req_a[W-1];
                        b_msb     <= req_b[W-1];
                        carry_q   <= (req_op == OP_ADD) ? req_cin :
                                     (req_op == OP_SUB);
                        sel_q     <= req_op[1] ? OP_ADD : req_op;
                        cnt       <= '0;
                        res_q     <= '0;
                        req_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= res_next;
                    if (last_pass) begin
                        cnt       <= '0;
                        a_sh      <= '0;
                        b_sh      <= '0;
                        carry_q   <= 1'b0;
                        sel_q     <= 2'b00;
                        rsp_valid <= 1'b1;
                        rsp_zero  <= (res_next == '0);
                        rsp_carry <= arith & alu_cout;
                        rsp_ovf   <= ovf_next;
                        state     <= DONE;
                    end else begin
                        cnt  <= cnt + 2'd1;
                        a_sh <= a_sh >> 4;
                        b_sh <= b_sh >> 4;
                        if (arith) begin
                            carry_q <= alu_cout;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
